// File: rtl/skew_lane_reg_if.sv
// ============================================================================
// Module      : skew_lane_reg_if
// Description : Load/stream bus between the operand loader and the skewed
//               lane register feeding the systolic array edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface skew_lane_reg_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int LANES = 4
);
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LENW = $clog2(DEPTH) + 1;

  logic                   en;
  logic                   wr;
  logic [LW-1:0]          wr_lane;
  logic [IW-1:0]          wr_idx;
  logic [WIDTH-1:0]       din;
  logic                   start;
  logic [LENW-1:0]        len;
  logic [LANES*WIDTH-1:0] dout;
  logic [LANES-1:0]       dout_valid;
  logic                   busy;
  logic                   done;

  // Loader side: drives writes and stream requests.
  modport master (
    output en, wr, wr_lane, wr_idx, din, start, len,
    input  dout, dout_valid, busy, done
  );

  // Register side.
  modport slave (
    input  en, wr, wr_lane, wr_idx, din, start, len,
    output dout, dout_valid, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/skew_lane_reg.sv
// ============================================================================
// Module      : skew_lane_reg
// Description : Per-lane operand store with indexed writes; on start streams
//               all lanes in parallel, lane l delayed by l cycles (diagonal
//               skew). Entries are consumed as they are streamed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skew_lane_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int LANES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  skew_lane_reg_if.slave bus
);

  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LENW = $clog2(DEPTH) + 1;
  localparam int CW   = $clog2(DEPTH + LANES) + 1;

  // S_FINISH is the single cycle that emits done after the last stream edge.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nx;

  logic [WIDTH-1:0]       mem [LANES][DEPTH];
  logic [LENW-1:0]        len_q;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          last_cnt;
  logic [LANES-1:0]       lane_valid;
  logic                   wr_ok;
  logic [LENW-1:0]        len_clamped;

  logic [LANES*WIDTH-1:0] dout_q;
  logic [LANES-1:0]       valid_q;
  logic                   busy_q;
  logic                   done_q;

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  // Zero-extend before comparing so non-power-of-two sizes are range checked.
  assign wr_ok = bus.wr
              && ({1'b0, bus.wr_lane} < (LW+1)'(LANES))
              && ({1'b0, bus.wr_idx}  < (IW+1)'(DEPTH));

  assign len_clamped = (bus.len > LENW'(DEPTH)) ? LENW'(DEPTH) : bus.len;

  // Final stream cycle index: last entry of the most delayed lane.
  assign last_cnt = CW'(len_q) + CW'(LANES) - CW'(2);

  // Lane l is presenting entry (cnt - l) when that index falls inside the stream.
  always_comb begin
    lane_valid = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_valid[l] = (cnt >= CW'(l)) && ((cnt - CW'(l)) < CW'(len_q));
    end
  end

  // State register; frozen while en is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (bus.en) begin
      state <= state_nx;
    end
  end

  // Next-state logic; a zero-length start goes straight to the done cycle.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nx = (bus.len == '0) ? S_FINISH : S_STREAM;
        end
      end
      S_STREAM: begin
        if (cnt == last_cnt) begin
          state_nx = S_FINISH;
        end
      end
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Storage, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int l = 0; l < LANES; l++) begin
        for (int k = 0; k < DEPTH; k++) begin
          mem[l][k] <= '0;
        end
      end
      len_q   <= '0;
      cnt     <= '0;
      dout_q  <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.en) begin
      dout_q  <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_ok) begin
            mem[bus.wr_lane][bus.wr_idx] <= bus.din;
          end
          if (bus.start) begin
            len_q <= len_clamped;
            cnt   <= '0;
          end
        end
        S_STREAM: begin
          busy_q <= 1'b1;
          cnt    <= cnt + CW'(1);
          for (int l = 0; l < LANES; l++) begin
            valid_q[l] <= lane_valid[l];
            dout_q[l*WIDTH +: WIDTH] <= lane_valid[l] ? mem[l][0] : '0;
            // Consume: head moves toward index 0, tail zero-fills.
            if (lane_valid[l]) begin
              for (int k = 0; k < DEPTH - 1; k++) begin
                mem[l][k] <= mem[l][k+1];
              end
              mem[l][DEPTH-1] <= '0;
            end
          end
          // Entries beyond len were never streamed; wipe everything on exit.
          if (cnt == last_cnt) begin
            for (int l = 0; l < LANES; l++) begin
              for (int k = 0; k < DEPTH; k++) begin
                mem[l][k] <= '0;
              end
            end
          end
        end
        S_FINISH: begin
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
